entropy_arbiter: RTL and testbench

Round-robin arbiter that shares the free-running ring-oscillator entropy counter between several random-number requesters, such as the minesweeper board generator and the Sokoban level shuffler. For each granted request it folds the raw 16-bit entropy word into a 16-bit LFSR over a fixed number of cycles. It then returns one conditioned WIDTH-bit value to the winner through a req/gnt/valid handshake. It sits between the entropy counter output and the game-logic consumers.

---
 rtl/entropy_arbiter.sv | 132 +++++++++++++
 tb/tb_entropy_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/entropy_arbiter.sv
// Round-robin arbiter that lends the ring-oscillator entropy counter to one requester
// at a time, folds it into a 16-bit LFSR and returns a conditioned WIDTH-bit value.
module entropy_arbiter #(
    parameter int NREQ       = 2,
    parameter int WIDTH      = 8,
    parameter int MIX_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      ent_in,
    input  logic [NREQ-1:0]  req,
    output logic [NREQ-1:0]  gnt,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             busy
);

    localparam int          IW        = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int          CW        = $clog2(MIX_CYCLES + 1);
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MIX,
        ST_GRANT,
        ST_RELEASE
    } state_t;

    state_t          state, state_next;
    logic [15:0]     lfsr, lfsr_mixed;
    logic [IW-1:0]   ptr, win, win_sel;
    logic [CW-1:0]   cnt;
    logic            found;
    logic            do_latch, do_mix, do_grant, do_clear;

    // One shift of the x^16+x^14+x^13+x^11+1 LFSR with the entropy word folded in;
    // an all-zero result would freeze the register, so it is replaced by the seed.
    function automatic logic [15:0] mix_step(input logic [15:0] x, input logic [15:0] e);
        logic [15:0] y;
        y = {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]} ^ e;
        return (y == 16'h0000) ? LFSR_SEED : y;
    endfunction

    assign lfsr_mixed = mix_step(lfsr, ent_in);
    assign busy       = (state != ST_IDLE);

    // Rotating priority search starting at ptr.
    always_comb begin
        logic [IW-1:0] cand;
        win_sel = '0;
        found   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            cand = IW'((int'(ptr) + i) % NREQ);
            if (!found && req[cand]) begin
                found   = 1'b1;
                win_sel = cand;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // NOTE: every signal driven here gets a default first, otherwise paths that skip
    // an assignment would infer latches.
    always_comb begin
        state_next = state;
        do_latch   = 1'b0;
        do_mix     = 1'b0;
        do_grant   = 1'b0;
        do_clear   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (found) begin
                    do_latch   = 1'b1;
                    state_next = ST_MIX;
                end
            end
            ST_MIX: begin
                if (!req[win]) begin
                    do_clear   = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    do_mix = 1'b1;
                    if (cnt == CW'(MIX_CYCLES - 1)) state_next = ST_GRANT;
                end
            end
            ST_GRANT: begin
                do_grant   = 1'b1;
                state_next = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (!req[win]) begin
                    do_clear   = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr  <= LFSR_SEED;
            ptr   <= '0;
            win   <= '0;
            cnt   <= '0;
            gnt   <= '0;
            valid <= 1'b0;
            data  <= '0;
        end else begin
            valid <= do_grant;
            if (do_latch) begin
                win <= win_sel;
                gnt <= NREQ'(1) << win_sel;
                cnt <= '0;
            end
            if (do_mix) begin
                lfsr <= lfsr_mixed;
                cnt  <= cnt + 1'b1;
                if (cnt == CW'(MIX_CYCLES - 1)) data <= lfsr_mixed[WIDTH-1:0];
            end
            if (do_grant) ptr <= (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;
            if (do_clear) gnt <= '0;
        end
    end

endmodule

// File: tb/tb_entropy_arbiter.sv
// Directed and randomized transactions against a transaction-level model of the
// entropy arbiter (round-robin winner choice plus LFSR folding of the entropy words).
module tb_entropy_arbiter;

    localparam int NREQ = 2;
    localparam int WIDTH = 8;
    localparam int MIX = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [15:0]      ent_in = '0;
    logic [NREQ-1:0]  req = '0;
    logic [NREQ-1:0]  gnt;
    logic             valid;
    logic [WIDTH-1:0] data;
    logic             busy;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] m_lfsr = 16'hACE1;
    int          m_ptr = 0;
    int          last_win = 0;

    entropy_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .MIX_CYCLES(MIX)) dut (
        .clk(clk), .rst(rst), .ent_in(ent_in), .req(req),
        .gnt(gnt), .valid(valid), .data(data), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [15:0] m_shift(input logic [15:0] x);
        return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
    endfunction

    function automatic logic [15:0] m_mix(input logic [15:0] x, input logic [15:0] e);
        logic [15:0] y;
        y = m_shift(x) ^ e;
        return (y == 16'h0) ? 16'hACE1 : y;
    endfunction

    function automatic int pick(input logic [NREQ-1:0] r, input int p);
        for (int i = 0; i < NREQ; i++)
            if (r[(p + i) % NREQ]) return (p + i) % NREQ;
        return -1;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        ent_in = '0;
        tick();
        rst = 1'b0;
        m_lfsr = 16'hACE1;
        m_ptr = 0;
    endtask

    // One full transaction starting from IDLE. mode: 0 random entropy, 1 zero entropy,
    // 2 zero entropy except the last word, chosen to drive the LFSR to all-zero.
    task automatic serve(input logic [NREQ-1:0] reqs, input int hold, input int mode);
        int              w;
        logic [NREQ-1:0] oh;
        logic [15:0]     e;
        w  = pick(reqs, m_ptr);
        oh = NREQ'(1) << w;
        req = reqs;
        ent_in = 16'($urandom);
        tick();
        check("gnt_on_grant", 32'(gnt), 32'(oh));
        check("busy_in_mix", 32'(busy), 32'd1);
        for (int k = 1; k <= MIX; k++) begin
            if (mode == 0)                   e = 16'($urandom);
            else if (mode == 2 && k == MIX)  e = m_shift(m_lfsr);
            else                             e = 16'h0;
            ent_in = e;
            m_lfsr = m_mix(m_lfsr, e);
            tick();
            check("valid_early", 32'(valid), 32'd0);
            check("gnt_held_mix", 32'(gnt), 32'(oh));
        end
        check("data_on_grant", 32'(data), 32'(m_lfsr[WIDTH-1:0]));
        ent_in = 16'($urandom);
        tick();
        check("valid_pulse", 32'(valid), 32'd1);
        check("gnt_at_valid", 32'(gnt), 32'(oh));
        check("data_at_valid", 32'(data), 32'(m_lfsr[WIDTH-1:0]));
        m_ptr = (w + 1) % NREQ;
        for (int h = 0; h < hold; h++) begin
            tick();
            check("valid_single", 32'(valid), 32'd0);
            check("gnt_release", 32'(gnt), 32'(oh));
            check("busy_release", 32'(busy), 32'd1);
            check("data_held", 32'(data), 32'(m_lfsr[WIDTH-1:0]));
        end
        req[w] = 1'b0;
        tick();
        check("gnt_cleared", 32'(gnt), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
        check("valid_after", 32'(valid), 32'd0);
        last_win = w;
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_data", 32'(data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;

        // Single request with zero entropy from reset
        serve(2'b01, 1, 1);
        check("single_data", 32'(data), 32'h1E);
        check("single_lfsr", 32'(dut.lfsr), 32'hCE1E);

        // Simultaneous requests: 0, then 1, then 0 again
        do_reset();
        serve(2'b11, 0, 0);
        check("rr_first", 32'(last_win), 32'd0);
        serve(2'b11, 1, 0);
        check("rr_second", 32'(last_win), 32'd1);
        serve(2'b11, 0, 0);
        check("rr_third", 32'(last_win), 32'd0);

        // Lock-up guard on the final mix step
        do_reset();
        serve(2'b01, 0, 2);
        check("lockup_lfsr", 32'(dut.lfsr), 32'hACE1);
        check("lockup_data", 32'(data), 32'hE1);

        // Abort on the second MIX cycle
        do_reset();
        req = 2'b01;
        ent_in = 16'h0;
        tick();
        check("abort_gnt", 32'(gnt), 32'b01);
        m_lfsr = m_mix(m_lfsr, 16'h0);
        tick();
        req = 2'b00;
        tick();
        check("abort_gnt_clear", 32'(gnt), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_valid", 32'(valid), 32'd0);
        check("abort_lfsr", 32'(dut.lfsr), 32'h59C3);
        check("abort_lfsr_model", 32'(dut.lfsr), 32'(m_lfsr));
        serve(2'b11, 0, 0);
        check("abort_ptr_kept", 32'(last_win), 32'd0);

        // Asynchronous reset in the middle of MIX
        req = 2'b10;
        ent_in = 16'($urandom);
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("midrst_gnt", 32'(gnt), 32'd0);
        check("midrst_valid", 32'(valid), 32'd0);
        check("midrst_data", 32'(data), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_lfsr", 32'(dut.lfsr), 32'hACE1);
        tick();
        rst = 1'b0;
        req = '0;
        m_lfsr = 16'hACE1;
        m_ptr = 0;
        serve(2'b01, 0, 1);
        check("midrst_redo_data", 32'(data), 32'h1E);

        // Slow release while the other requester waits
        serve(2'b11, 10, 0);
        check("slow_winner", 32'(last_win), 32'd1);
        serve(2'b01, 0, 0);
        check("slow_next", 32'(last_win), 32'd0);

        // Randomized transactions
        for (int n = 0; n < 25; n++)
            serve(NREQ'($urandom_range(1, 3)), int'($urandom_range(0, 3)), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
